// File: rtl/engine_array_dispatcher_if.sv
// Channel bundle between the dispatcher and its environment: upstream PC channel,
// per-lane engine input/output channels, merged downstream channel and status.
interface engine_array_dispatcher_if #(
    parameter int PC_WIDTH            = 8,
    parameter int CC_ID_BITS          = 1,
    parameter int LATENCY_COUNT_WIDTH = 8,
    parameter int LANE_BITS           = 2
);
    localparam int DW = PC_WIDTH + CC_ID_BITS;
    localparam int LW = LATENCY_COUNT_WIDTH;
    localparam int N  = 2 ** LANE_BITS;

    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_data;
    logic [LW-1:0]     in_latency;

    logic [N-1:0]      lane_in_valid;
    logic [N-1:0]      lane_in_ready;
    logic [N*DW-1:0]   lane_in_data;
    logic [N*LW-1:0]   lane_in_latency;

    logic [N-1:0]      lane_out_valid;
    logic [N-1:0]      lane_out_ready;
    logic [N*DW-1:0]   lane_out_data;
    logic [N*LW-1:0]   lane_out_latency;

    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [LW-1:0]     out_latency;

    logic [N-1:0]      lane_running;
    logic [N-1:0]      lane_full;
    logic              running;
    logic              full;

    // Environment side: feeds PCs, models the engines and the downstream sink.
    modport master (
        output in_valid, in_data, in_latency,
        output lane_in_ready,
        output lane_out_valid, lane_out_data, lane_out_latency,
        output out_ready,
        output lane_running, lane_full,
        input  in_ready,
        input  lane_in_valid, lane_in_data, lane_in_latency,
        input  lane_out_ready,
        input  out_valid, out_data, out_latency,
        input  running, full
    );

    // Dispatcher side.
    modport slave (
        input  in_valid, in_data, in_latency,
        input  lane_in_ready,
        input  lane_out_valid, lane_out_data, lane_out_latency,
        input  out_ready,
        input  lane_running, lane_full,
        output in_ready,
        output lane_in_valid, lane_in_data, lane_in_latency,
        output lane_out_ready,
        output out_valid, out_data, out_latency,
        output running, full
    );
endinterface

// File: rtl/engine_array_dispatcher.sv
// Spreads incoming PCs round-robin over N engine lanes and merges the lane outputs
// round-robin into a 2-entry skid FIFO that drives the downstream channel.
module engine_array_dispatcher #(
    parameter int PC_WIDTH            = 8,
    parameter int CC_ID_BITS          = 1,
    parameter int LATENCY_COUNT_WIDTH = 8,
    parameter int LANE_BITS           = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    engine_array_dispatcher_if.slave    bus
);
    localparam int DW = PC_WIDTH + CC_ID_BITS;
    localparam int LW = LATENCY_COUNT_WIDTH;
    localparam int N  = 2 ** LANE_BITS;
    localparam logic [LW-1:0] LAT_MAX = '1;

    // Circular first-set search starting at ptr; returns {found, index}.
    // Iterating from the farthest offset down lets the nearest request win last.
    function automatic logic [LANE_BITS:0] rr_pick(input logic [N-1:0]         req,
                                                   input logic [LANE_BITS-1:0] ptr);
        logic [LANE_BITS:0]   result;
        logic [LANE_BITS-1:0] idx;
        result = '0;
        for (int o = N - 1; o >= 0; o--) begin
            idx = ptr + LANE_BITS'(o);
            if (req[idx]) begin
                result = {1'b1, idx};
            end
        end
        return result;
    endfunction

    // ---------------------------------------------------------------- dispatch
    logic [LANE_BITS-1:0] dptr_reg, dptr_next;
    logic [N-1:0]         eligible;
    logic                 disp_found;
    logic [LANE_BITS-1:0] disp_lane;
    logic                 in_fire;

    assign eligible                = bus.lane_in_ready & ~bus.lane_full;
    assign {disp_found, disp_lane} = rr_pick(eligible, dptr_reg);
    assign bus.in_ready            = |eligible;
    assign in_fire                 = bus.in_valid & disp_found;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane_in
            assign bus.lane_in_valid[gi]            = in_fire && (disp_lane == LANE_BITS'(gi));
            assign bus.lane_in_data[gi*DW +: DW]    = bus.in_data;
            assign bus.lane_in_latency[gi*LW +: LW] = bus.in_latency;
        end
    endgenerate

    // ------------------------------------------------------------------- merge
    logic [LANE_BITS-1:0] mptr_reg, mptr_next;
    logic                 merge_found;
    logic [LANE_BITS-1:0] merge_lane;
    logic                 fifo_can_accept;
    logic                 grant;
    logic [DW-1:0]        lane_out_data_arr [N];
    logic [LW-1:0]        lane_out_lat_arr  [N];
    logic [DW-1:0]        sel_data;
    logic [LW-1:0]        sel_lat;
    logic [LW-1:0]        push_lat;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane_out
            assign lane_out_data_arr[gi] = bus.lane_out_data[gi*DW +: DW];
            assign lane_out_lat_arr[gi]  = bus.lane_out_latency[gi*LW +: LW];
            assign bus.lane_out_ready[gi] = grant && (merge_lane == LANE_BITS'(gi));
        end
    endgenerate

    // ---------------------------------------------------------- output FIFO
    logic [DW-1:0] fifo_data_reg [2];
    logic [LW-1:0] fifo_lat_reg  [2];
    logic          wr_ptr_reg, wr_ptr_next;
    logic          rd_ptr_reg, rd_ptr_next;
    logic [1:0]    count_reg, count_next;
    logic          out_valid_reg;
    logic          pop;

    assign {merge_found, merge_lane} = rr_pick(bus.lane_out_valid, mptr_reg);
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign fifo_can_accept = (count_reg != 2'd2) || bus.out_ready;
    assign grant           = merge_found && fifo_can_accept && !rst;
    assign pop             = out_valid_reg && bus.out_ready;

    assign sel_data = lane_out_data_arr[merge_lane];
    assign sel_lat  = lane_out_lat_arr[merge_lane];
    assign push_lat = (sel_lat == LAT_MAX) ? LAT_MAX : sel_lat + LW'(1);

    always_comb begin
        dptr_next   = dptr_reg;
        mptr_next   = mptr_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (in_fire) begin
            dptr_next = disp_lane + LANE_BITS'(1);
        end
        if (grant) begin
            mptr_next   = merge_lane + LANE_BITS'(1);
            wr_ptr_next = ~wr_ptr_reg;
        end
        if (pop) begin
            rd_ptr_next = ~rd_ptr_reg;
        end
        case ({grant, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dptr_reg      <= '0;
            mptr_reg      <= '0;
            wr_ptr_reg    <= 1'b0;
            rd_ptr_reg    <= 1'b0;
            count_reg     <= 2'd0;
            out_valid_reg <= 1'b0;
        end else begin
            dptr_reg      <= dptr_next;
            mptr_reg      <= mptr_next;
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            out_valid_reg <= (count_next != 2'd0);
        end
    end

    // Storage only captures granted (valid) data, so lane don't-cares never land here.
    always_ff @(posedge clk) begin
        if (grant) begin
            fifo_data_reg[wr_ptr_reg] <= sel_data;
            fifo_lat_reg[wr_ptr_reg]  <= push_lat;
        end
    end

    assign bus.out_valid   = out_valid_reg;
    assign bus.out_data    = out_valid_reg ? fifo_data_reg[rd_ptr_reg] : '0;
    assign bus.out_latency = out_valid_reg ? fifo_lat_reg[rd_ptr_reg]  : '0;

    // ------------------------------------------------------------------ status
    assign bus.running = (|bus.lane_running) | out_valid_reg;
    assign bus.full    = &bus.lane_full;

endmodule

// File: tb/tb_engine_array_dispatcher.sv
// Directed bench for engine_array_dispatcher: dispatch order, merge arbitration,
// skid-FIFO back-pressure, latency saturation and reset behaviour.
module tb_engine_array_dispatcher;
    localparam int PCW = 8;
    localparam int CCB = 1;
    localparam int LW  = 8;
    localparam int LB  = 2;
    localparam int DW  = PCW + CCB;
    localparam int N   = 2 ** LB;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    engine_array_dispatcher_if #(
        .PC_WIDTH(PCW), .CC_ID_BITS(CCB), .LATENCY_COUNT_WIDTH(LW), .LANE_BITS(LB)
    ) bus ();

    engine_array_dispatcher #(
        .PC_WIDTH(PCW), .CC_ID_BITS(CCB), .LATENCY_COUNT_WIDTH(LW), .LANE_BITS(LB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [LW-1:0] lat;
    } entry_t;

    int     tests    = 0;
    int     failures = 0;
    entry_t sb[$];
    int     disp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane_out(input int lane, input logic [DW-1:0] d, input logic [LW-1:0] l);
        bus.lane_out_data[lane*DW +: DW]    = d;
        bus.lane_out_latency[lane*LW +: LW] = l;
    endtask

    // One dispatch transfer; target lane comes from the dispatch scoreboard.
    task automatic disp_cycle(input string tag);
        int exp_lane;
        #1;
        exp_lane = disp_q.pop_front();
        check({tag, "/in_ready"}, 32'(bus.in_ready), 32'd1);
        check({tag, "/lane_in_valid"}, 32'(bus.lane_in_valid), 32'(4'b0001 << exp_lane));
        check({tag, "/lane_in_data"}, 32'(bus.lane_in_data[exp_lane*DW +: DW]), 32'(bus.in_data));
        check({tag, "/lane_in_lat"}, 32'(bus.lane_in_latency[exp_lane*LW +: LW]), 32'(bus.in_latency));
        $display("[TB] dispatch %s data=0x%0h -> lane %0d", tag, bus.in_data, exp_lane);
        tick();
    endtask

    // One merge-side cycle: checks output head against the scoreboard, checks the
    // expected grant, and records the granted entry with its expected latency.
    task automatic merge_cycle(input string tag, input logic [N-1:0] exp_grant,
                               input logic [LW-1:0] exp_lat);
        entry_t e;
        #1;
        check({tag, "/out_valid"}, 32'(bus.out_valid), 32'(sb.size() != 0));
        if (sb.size() != 0 && bus.out_ready) begin
            e = sb.pop_front();
            check({tag, "/out_data"}, 32'(bus.out_data), 32'(e.data));
            check({tag, "/out_lat"}, 32'(bus.out_latency), 32'(e.lat));
            $display("[TB] output %s data=0x%0h lat=%0d", tag, bus.out_data, bus.out_latency);
        end
        check({tag, "/lane_out_ready"}, 32'(bus.lane_out_ready), 32'(exp_grant));
        if (exp_grant != '0) begin
            for (int i = 0; i < N; i++) begin
                if (exp_grant[i]) begin
                    e.data = bus.lane_out_data[i*DW +: DW];
                    e.lat  = exp_lat;
                end
            end
            sb.push_back(e);
        end
        tick();
    endtask

    initial begin
        rst                  = 1'b1;
        bus.in_valid         = 1'b0;
        bus.in_data          = '0;
        bus.in_latency       = '0;
        bus.lane_in_ready    = '0;
        bus.lane_out_valid   = '0;
        bus.lane_out_data    = '0;
        bus.lane_out_latency = '0;
        bus.out_ready        = 1'b0;
        bus.lane_running     = '0;
        bus.lane_full        = '0;
        tick();
        tick();

        // Reset state; lane_out_ready held low while rst even with requests pending.
        bus.lane_out_valid = 4'b1111;
        #1;
        check("rst/out_valid", 32'(bus.out_valid), 32'd0);
        check("rst/out_data", 32'(bus.out_data), 32'd0);
        check("rst/out_lat", 32'(bus.out_latency), 32'd0);
        check("rst/lane_out_ready", 32'(bus.lane_out_ready), 32'd0);
        check("rst/in_ready", 32'(bus.in_ready), 32'd0);
        check("rst/running", 32'(bus.running), 32'd0);
        check("rst/full", 32'(bus.full), 32'd0);
        bus.lane_out_valid = '0;
        tick();
        rst = 1'b0;

        // Eight back-to-back inputs with every lane ready.
        bus.lane_in_ready = 4'b1111;
        bus.in_valid      = 1'b1;
        for (int k = 0; k < 8; k++) disp_q.push_back(k % N);
        for (int k = 0; k < 8; k++) begin
            bus.in_data    = DW'(k * 37 + 5);
            bus.in_latency = LW'(k + 1);
            disp_cycle("b2b");
        end

        // Lane 1 full with dptr at 1: goes to lane 2, then dptr = 3.
        disp_q.push_back(0);
        bus.in_data = 9'h0A1;
        disp_cycle("to_lane0");
        bus.lane_full = 4'b0010;
        disp_q.push_back(2);
        bus.in_data = 9'h0B2;
        disp_cycle("skip_full");
        bus.lane_full = '0;
        disp_q.push_back(3);
        bus.in_data = 9'h1C3;
        disp_cycle("after_skip");
        bus.in_valid      = 1'b0;
        bus.lane_in_ready = '0;
        #1;
        check("idle/in_ready", 32'(bus.in_ready), 32'd0);
        check("idle/lane_in_valid", 32'(bus.lane_in_valid), 32'd0);
        check("idle/full", 32'(bus.full), 32'd0);
        tick();

        // Lanes 0 and 3 streaming with out_ready high: grants alternate 0,3,0,3.
        bus.out_ready      = 1'b1;
        bus.lane_out_valid = 4'b1001;
        for (int c = 0; c < 4; c++) begin
            set_lane_out(0, DW'(16 + c), LW'(c));
            set_lane_out(3, DW'(200 + c), LW'(10 + c));
            merge_cycle("rr03", (c % 2 == 0) ? 4'b0001 : 4'b1000,
                        (c % 2 == 0) ? LW'(c + 1) : LW'(11 + c));
        end
        bus.lane_out_valid = '0;
        merge_cycle("rr03_drain", 4'b0000, '0);

        // Downstream stalled five cycles: exactly two grants, then none.
        bus.out_ready      = 1'b0;
        bus.lane_out_valid = 4'b1001;
        set_lane_out(0, 9'h055, 8'd40);
        set_lane_out(3, 9'h1AA, 8'd50);
        merge_cycle("stall1", 4'b0001, 8'd41);
        set_lane_out(0, 9'h066, 8'd60);
        merge_cycle("stall2", 4'b1000, 8'd51);
        merge_cycle("stall3", 4'b0000, '0);
        merge_cycle("stall4", 4'b0000, '0);
        merge_cycle("stall5", 4'b0000, '0);
        // Release: full FIFO pops and pushes in the same cycle.
        bus.out_ready = 1'b1;
        merge_cycle("release", 4'b0001, 8'd61);
        bus.lane_out_valid = '0;
        merge_cycle("release_d1", 4'b0000, '0);
        merge_cycle("release_d2", 4'b0000, '0);
        merge_cycle("release_d3", 4'b0000, '0);

        // Latency saturation and ordinary increment.
        bus.lane_out_valid = 4'b0010;
        set_lane_out(1, 9'h123, 8'd255);
        merge_cycle("lat_sat", 4'b0010, 8'd255);
        bus.lane_out_valid = 4'b0100;
        set_lane_out(2, 9'h045, 8'd5);
        merge_cycle("lat_inc", 4'b0100, 8'd6);
        bus.lane_out_valid = '0;
        merge_cycle("lat_d1", 4'b0000, '0);
        merge_cycle("lat_d2", 4'b0000, '0);

        // Reset with two buffered entries and non-zero pointers (mptr=3 here).
        bus.out_ready      = 1'b0;
        bus.lane_out_valid = 4'b0110;
        bus.lane_in_ready  = 4'b1111;
        bus.in_valid       = 1'b1;
        bus.in_data        = 9'h0EE;
        set_lane_out(1, 9'h011, 8'd1);
        set_lane_out(2, 9'h022, 8'd2);
        merge_cycle("prerst1", 4'b0010, 8'd2);
        bus.in_valid = 1'b0;
        merge_cycle("prerst2", 4'b0100, 8'd3);
        rst           = 1'b1;
        bus.lane_full = 4'b1111;
        #1;
        check("inrst/lane_out_ready", 32'(bus.lane_out_ready), 32'd0);
        check("inrst/in_ready", 32'(bus.in_ready), 32'd0);
        check("inrst/full", 32'(bus.full), 32'd1);
        tick();
        #1;
        check("postrst/out_valid", 32'(bus.out_valid), 32'd0);
        check("postrst/out_data", 32'(bus.out_data), 32'd0);
        check("postrst/out_lat", 32'(bus.out_latency), 32'd0);
        bus.lane_running = 4'b0100;
        #1;
        check("postrst/running", 32'(bus.running), 32'd1);
        bus.lane_running = '0;
        sb.delete();
        tick();

        // Pointers back at zero: dispatch and merge both pick lane 0.
        rst                = 1'b0;
        bus.lane_full      = '0;
        bus.in_valid       = 1'b1;
        bus.lane_out_valid = 4'b1111;
        bus.out_ready      = 1'b1;
        set_lane_out(0, 9'h1F0, 8'd7);
        #1;
        check("postrst/dptr0", 32'(bus.lane_in_valid), 32'h1);
        merge_cycle("postrst_mptr0", 4'b0001, 8'd8);
        bus.in_valid       = 1'b0;
        bus.lane_out_valid = '0;
        merge_cycle("postrst_out", 4'b0000, '0);
        check("final/sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule

// File: doc/engine_array_dispatcher.md
ENGINE_ARRAY_DISPATCHER -- requirements
Module: engine_array_dispatcher

Interface
REQ-001 Parameter PC_WIDTH, default 8, program-counter width carried on channels.
REQ-002 Parameter CC_ID_BITS, default 1, character-context id width; channel data width DW = PC_WIDTH+CC_ID_BITS.
REQ-003 Parameter LATENCY_COUNT_WIDTH, default 8, width LW of channel latency field.
REQ-004 Parameter LANE_BITS, default 2, number of engine lanes N = 2**LANE_BITS (LANE_BITS>=1).
REQ-005 Port clk  in  1  sole clock, all state on rising edge.
REQ-006 Port rst  in  1  synchronous, active-high reset.
REQ-007 Port in_valid / in_ready / in_data / in_latency  in/out/in/in  1/1/DW/LW  upstream PC channel.
REQ-008 Port lane_in_valid / lane_in_ready / lane_in_data / lane_in_latency  out/in/out/out  N/N/N*DW/N*LW  per-lane input channels, lane i at slice i.
REQ-009 Port lane_out_valid / lane_out_ready / lane_out_data / lane_out_latency  in/out/in/in  N/N/N*DW/N*LW  per-lane output channels.
REQ-010 Port out_valid / out_ready / out_data / out_latency  out/in/out/out  1/1/DW/LW  merged downstream PC channel.
REQ-011 Port lane_running / lane_full  in/in  N/N  per-lane engine status.
REQ-012 Port running / full  out/out  1/1  aggregate status.

Function
REQ-013 A transfer on any channel occurs when valid and ready are both high on a clock edge.
REQ-014 Dispatch is combinational: in_ready = OR over i of (lane_in_ready[i] & ~lane_full[i]); eligible lane set E = those bits.
REQ-015 The dispatch target is the first lane in E at or after dispatch pointer dptr, circular search; only that lane sees lane_in_valid high, and only while in_valid is high.
REQ-016 lane_in_data and lane_in_latency of every lane equal in_data and in_latency; non-target lanes have lane_in_valid low.
REQ-017 On an input transfer to lane k, dptr <= (k+1) mod N; otherwise dptr holds.
REQ-018 Merge: round-robin arbiter over lane_out_valid with pointer mptr, same circular-search rule; the winner w is granted only when the output buffer can accept (REQ-020).
REQ-019 lane_out_ready[w] is high only for the granted lane; all others low. On a grant, mptr <= (w+1) mod N.
REQ-020 Output buffer is a 2-entry skid FIFO; it accepts when its count < 2, or count = 2 and out_ready is high that cycle (simultaneous pop/push permitted).
REQ-021 out_valid is driven from a register (count != 0); out_data/out_latency are the head entry; latency from lane grant to out_valid is exactly 1 cycle when empty.
REQ-022 Stored latency = min(lane_out_latency[w] + 1, 2**LW-1), saturating, no wrap.
REQ-023 Output order: FIFO order of grant; no entry is dropped or duplicated; full throughput is one transfer per cycle in steady state.
REQ-024 Pop with count = 1 and push same cycle: count stays 1, new entry becomes head on next cycle.
REQ-025 running = OR(lane_running) | out_valid; full = AND(lane_full).
REQ-026 Data and latency inputs are don't-care while the corresponding valid is low; no X propagates into state.

Reset
REQ-027 While rst is high on an edge: dptr=0, mptr=0, FIFO count=0, out_valid=0; out_data/out_latency read 0.
REQ-028 Reset mid-operation discards buffered entries; combinational outputs (in_ready, lane_in_valid, lane_out_ready) stay functions of inputs, except lane_out_ready is 0 during rst.
REQ-029 Reset takes effect on the first edge with rst high; no extra recovery cycles.

Verification
REQ-030 N=4, all lanes ready, 8 back-to-back inputs -> lanes 0,1,2,3,0,1,2,3 receive them in order, in_ready constant 1.
REQ-031 lane 1 full, lanes 0,2,3 ready, dptr=1 -> transfer goes to lane 2, dptr becomes 3.
REQ-032 lanes 0 and 3 valid every cycle, out_ready=1, mptr=0 -> grants alternate 0,3,0,3; out_valid high from cycle 2 onward at 1 transfer/cycle.
REQ-033 out_ready=0 for 5 cycles with lanes valid -> exactly 2 grants then lane_out_ready all 0; on release, both stored entries emerge in grant order.
REQ-034 lane_out_latency = 2**LW-1 -> out_latency = 2**LW-1; lane_out_latency = 5 -> out_latency = 6.
REQ-035 rst asserted with 2 buffered entries -> next cycle out_valid=0, dptr=mptr=0, all lanes full -> full=1, in_ready=0.
